// File: rtl/clock_edge_monitor_pkg.sv
// Shared constants for the divided-clock edge monitor: FSM encoding and defaults.
package clock_edge_monitor_pkg;

  // Monitor FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // Default parameter values for the monitor.
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_CNT_W       = 16;
  localparam int unsigned DEFAULT_TIMEOUT     = 1000;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_edge_monitor.sv
// Samples a divided clock as data, emits rise/fall enable ticks, measures its
// rise-to-rise period in clk cycles and flags a stalled divider.
module clock_edge_monitor
  import clock_edge_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

  logic             sync_last;
  logic             prev_q, prev_d;
  logic             rise_c, fall_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             stalled_q, stalled_d;
  logic             tick_rise_q, tick_rise_d;
  logic             tick_fall_q, tick_fall_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (slow_clk_in),
    .q     (sync_last)
  );

  // Edge detection against the one-cycle history of the synchronised level.
  always_comb begin
    prev_d      = sync_last;
    rise_c      = sync_last & ~prev_q;
    fall_c      = ~sync_last & prev_q;
    tick_rise_d = rise_c;
    tick_fall_d = fall_c;
  end

  // Saturating cycle counter, restarted at 1 on every detected rise.
  always_comb begin
    cnt_d = cnt_q;
    if (rise_c) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Period/stall FSM; a rise always takes priority over the timeout.
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    stalled_d      = stalled_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rise_c) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
        end else if (cnt_q == CNT_TIMEOUT) begin
          state_d   = ST_STALL;
          stalled_d = 1'b1;
        end
      end
      ST_STALL: begin
        // The interval spanning a stall is meaningless, so no period report.
        if (rise_c) begin
          state_d   = ST_RUN;
          stalled_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        stalled_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q         <= 1'b0;
      cnt_q          <= '0;
      state_q        <= ST_IDLE;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      tick_rise_q    <= 1'b0;
      tick_fall_q    <= 1'b0;
    end else begin
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      tick_rise_q    <= tick_rise_d;
      tick_fall_q    <= tick_fall_d;
    end
  end

  assign tick_rise    = tick_rise_q;
  assign tick_fall    = tick_fall_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Self-checking bench for clock_edge_monitor: two instances (wide counter /
// narrow saturating counter) share one stimulus and are compared every cycle
// against an event-level model of ticks, periods and stalls.
module tb_clock_edge_monitor;

  localparam int unsigned S_M = 2;
  localparam int unsigned W_M = 16;
  localparam int unsigned TO_M = 20;
  localparam int unsigned S_S = 3;
  localparam int unsigned W_S = 4;
  localparam int unsigned TO_S = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slow_clk_in = 1'b0;

  logic           tr_m, tf_m, pv_m, st_m;
  logic [W_M-1:0] per_m;
  logic           tr_s, tf_s, pv_s, st_s;
  logic [W_S-1:0] per_s;

  clock_edge_monitor #(.SYNC_STAGES(S_M), .CNT_W(W_M), .TIMEOUT(TO_M)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in),
    .tick_rise(tr_m), .tick_fall(tf_m), .period(per_m),
    .period_valid(pv_m), .stalled(st_m)
  );

  clock_edge_monitor #(.SYNC_STAGES(S_S), .CNT_W(W_S), .TIMEOUT(TO_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in),
    .tick_rise(tr_s), .tick_fall(tf_s), .period(per_s),
    .period_valid(pv_s), .stalled(st_s)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[d] is the input level sampled d clk edges ago; a tick for a level
  // change first sampled at edge k is visible right after edge k+S.
  bit          hist[$];
  int unsigned cyc;
  int unsigned stage[2] = '{S_M, S_S};
  int unsigned tmo[2]   = '{TO_M, TO_S};
  int unsigned maxv[2]  = '{(1 << W_M) - 1, (1 << W_S) - 1};
  bit          er[2], ef[2], pv[2], stl[2], seen[2];
  int unsigned last[2], per[2];

  function automatic bit hl(int unsigned d);
    return (d < hist.size()) ? hist[d] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        er[i] = 0; ef[i] = 0; pv[i] = 0; stl[i] = 0; seen[i] = 0;
        last[i] = 0; per[i] = 0;
      end
    end else begin
      hist.push_front(slow_clk_in);
      if (hist.size() > 8) void'(hist.pop_back());
      cyc++;
      for (int i = 0; i < 2; i++) begin
        er[i] = hl(stage[i]) & ~hl(stage[i] + 1);
        ef[i] = ~hl(stage[i]) & hl(stage[i] + 1);
        pv[i] = 0;
        if (er[i]) begin
          if (seen[i] && !stl[i]) begin
            pv[i]  = 1;
            per[i] = ((cyc - last[i]) > maxv[i]) ? maxv[i] : (cyc - last[i]);
          end
          seen[i] = 1;
          stl[i]  = 0;
          last[i] = cyc;
        end else if (seen[i] && !stl[i] && (cyc - last[i]) == tmo[i]) begin
          stl[i] = 1;
        end
      end
    end
  end

  logic [W_M+3:0] obs_m, exp_m;
  logic [W_S+3:0] obs_s, exp_s;
  assign obs_m = {tr_m, tf_m, pv_m, st_m, per_m};
  assign obs_s = {tr_s, tf_s, pv_s, st_s, per_s};
  assign exp_m = {er[0], ef[0], pv[0], stl[0], W_M'(per[0])};
  assign exp_s = {er[1], ef[1], pv[1], stl[1], W_S'(per[1])};

  // ---------------- stimulus helpers ----------------
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          wave[$];

  function automatic void add(input bit lvl, input int unsigned n);
    for (int k = 0; k < int'(n); k++) wave.push_back(lvl);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    slow_clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (obs_m !== '0) begin n_fail++; $display("FAIL reset_main got=%h exp=0", obs_m); end
    n_tests++;
    if (obs_s !== '0) begin n_fail++; $display("FAIL reset_small got=%h exp=0", obs_s); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_divider();
    int unsigned rises = 0, pvs = 0;
    bit          st_seen = 0;
    wave.delete();
    for (int r = 0; r < 10; r++) begin add(1, 2); add(0, 2); end
    add(0, 4);
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL divider_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL divider_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      if (tr_m) rises++;
      if (st_m) st_seen = 1;
      if (pv_m) begin
        pvs++;
        n_tests++;
        if (per_m !== 16'd4) begin n_fail++; $display("FAIL divider_period got=%0d exp=4", per_m); end
      end
    end
    n_tests++;
    if (rises != 10) begin n_fail++; $display("FAIL divider_rises got=%0d exp=10", rises); end
    n_tests++;
    if (pvs != 9) begin n_fail++; $display("FAIL divider_pv_count got=%0d exp=9", pvs); end
    n_tests++;
    if (st_seen) begin n_fail++; $display("FAIL divider_stalled got=1 exp=0"); end
  endtask

  task automatic test_pattern();
    int  lr = 0;
    bit  have_r = 0;
    wave.delete();
    for (int r = 0; r < 4; r++) begin add(1, 5); add(0, 3); end
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL pattern_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL pattern_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      if (tr_m) begin lr = i; have_r = 1; end
      if (tf_m && have_r) begin
        n_tests++;
        if (i - lr != 5) begin n_fail++; $display("FAIL pattern_fall_gap got=%0d exp=5", i - lr); end
      end
      if (pv_m) begin
        n_tests++;
        if (per_m !== 16'd8) begin n_fail++; $display("FAIL pattern_period got=%0d exp=8", per_m); end
      end
    end
  endtask

  task automatic test_stall();
    int lr = 0;
    bit st_prev = 0, stall_seen = 0, after_stall = 0;
    int post_rises = 0;
    wave.delete();
    add(1, 5); add(0, 3); add(0, 30);
    add(1, 5); add(0, 3); add(1, 5); add(0, 3);
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL stall_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL stall_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      if (st_m && !st_prev) begin
        stall_seen = 1;
        n_tests++;
        if (i - lr != int'(TO_M)) begin n_fail++; $display("FAIL stall_delay got=%0d exp=%0d", i - lr, TO_M); end
        n_tests++;
        if (per_m !== 16'd8) begin n_fail++; $display("FAIL stall_period_hold got=%0d exp=8", per_m); end
      end
      if (tr_m) begin
        if (stall_seen) begin
          post_rises++;
          n_tests++;
          if (post_rises == 1 && (pv_m !== 1'b0 || st_m !== 1'b0)) begin
            n_fail++; $display("FAIL stall_exit got pv=%b st=%b exp pv=0 st=0", pv_m, st_m);
          end else if (post_rises == 2 && (pv_m !== 1'b1 || per_m !== 16'd8)) begin
            n_fail++; $display("FAIL stall_resume got pv=%b per=%0d exp pv=1 per=8", pv_m, per_m);
          end
        end
        lr = i;
      end
      st_prev = st_m;
    end
    n_tests++;
    if (!stall_seen || post_rises != 2) begin
      n_fail++; $display("FAIL stall_seen got seen=%b rises=%0d exp seen=1 rises=2", stall_seen, post_rises);
    end
    after_stall = st_m;
    n_tests++;
    if (after_stall !== 1'b0) begin n_fail++; $display("FAIL stall_cleared got=%b exp=0", after_stall); end
  endtask

  task automatic test_timeout_boundary();
    int pvs = 0;
    wave.delete();
    for (int r = 0; r < 3; r++) begin add(1, 10); add(0, 10); end
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL boundary_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL boundary_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      n_tests++;
      if (st_m !== 1'b0) begin n_fail++; $display("FAIL boundary_stalled i=%0d got=1 exp=0", i); end
      if (pv_m) begin
        pvs++;
        if (pvs > 1) begin
          n_tests++;
          if (per_m !== 16'(TO_M)) begin n_fail++; $display("FAIL boundary_period got=%0d exp=%0d", per_m, TO_M); end
        end
      end
    end
    n_tests++;
    if (pvs != 3) begin n_fail++; $display("FAIL boundary_pv_count got=%0d exp=3", pvs); end
  endtask

  task automatic test_small_counter();
    int unsigned exp_per[$] = '{14, 14, 14, 14, 15, 15};
    int unsigned got = 0;
    wave.delete();
    for (int r = 0; r < 4; r++) begin add(1, 7); add(0, 7); end
    for (int r = 0; r < 3; r++) begin add(1, 8); add(0, 7); end
    add(0, 25);
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL small_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL small_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      if (pv_s) begin
        n_tests++;
        if (got >= exp_per.size() || per_s !== W_S'(exp_per[got]) || st_s !== 1'b0) begin
          n_fail++; $display("FAIL small_period n=%0d got=%0d st=%b", got, per_s, st_s);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 6) begin n_fail++; $display("FAIL small_pv_count got=%0d exp=6", got); end
    n_tests++;
    if (st_s !== 1'b1 || per_s !== 4'd15) begin
      n_fail++; $display("FAIL small_saturate got st=%b per=%0d exp st=1 per=15", st_s, per_s);
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b1;
    wave.delete();
    for (int r = 0; r < 30; r++) begin
      add(lvl, $urandom_range(1, 25));
      lvl = ~lvl;
    end
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL random_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL random_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
    end
  endtask

  task automatic test_async_reset();
    int rises = 0, pvs = 0;
    wave.delete();
    add(1, 5); add(0, 3); add(1, 3);
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL areset_pre_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_m !== '0) begin n_fail++; $display("FAIL areset_main got=%h exp=0", obs_m); end
    n_tests++;
    if (obs_s !== '0) begin n_fail++; $display("FAIL areset_small got=%h exp=0", obs_s); end
    repeat (3) begin
      @(negedge clk); slow_clk_in = ~slow_clk_in;
    end
    @(negedge clk);
    slow_clk_in = 1'b0;
    rst_n = 1'b1;
    wave.delete();
    add(0, 2); add(1, 4); add(0, 4); add(1, 4); add(0, 8);
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk); slow_clk_in = wave[i];
      @(posedge clk); #2;
      n_tests++;
      if (obs_m !== exp_m) begin n_fail++; $display("FAIL areset_post_main i=%0d got=%h exp=%h", i, obs_m, exp_m); end
      n_tests++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL areset_post_small i=%0d got=%h exp=%h", i, obs_s, exp_s); end
      if (tr_m) rises++;
      if (pv_m) begin
        pvs++;
        n_tests++;
        if (rises != 2 || per_m !== 16'd8) begin
          n_fail++; $display("FAIL areset_first_period got rise=%0d per=%0d exp rise=2 per=8", rises, per_m);
        end
      end
    end
    n_tests++;
    if (rises != 2 || pvs != 1) begin
      n_fail++; $display("FAIL areset_counts got rises=%0d pv=%0d exp rises=2 pv=1", rises, pvs);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_pattern();
    test_stall();
    test_timeout_boundary();
    test_small_counter();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
